beamform_core: RTL and testbench

Parametrised delay-and-sum beamforming core for the microphone array. Takes one packed frame of NUM_CH signed PCM samples per `in_valid` strobe from the per-channel decimators and delays each channel by a runtime-programmable number of frames. It sums the channels with a time-multiplexed accumulator and emits one scaled sum per frame to the I2S serialiser. It replaces the fixed 16-channel, preset-delay path with programmable per-channel delays, generic widths, a frame handshake and overrun reporting.

---
 rtl/beamform_core.sv | 134 +++++++++++++
 tb/tb_beamform_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/beamform_core.sv
// rtl/beamform_core.sv - delay-and-sum beamformer with programmable per-channel frame delays
// Optional output saturation: define BEAMFORM_SAT_EN.
module beamform_core #(
    parameter int NUM_CH    = 16,
    parameter int DATA_W    = 19,
    parameter int MAX_DELAY = 31,
    parameter int OUT_W     = 32,
    parameter int SHIFT     = 0,
    localparam int CH_W     = $clog2(NUM_CH),
    localparam int DL_W     = $clog2(MAX_DELAY + 1),
    localparam int SUM_W    = DATA_W + CH_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [DL_W-1:0]          cfg_delay,
    input  logic                     ovr_clr,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     busy,
    output logic                     overrun
);
    localparam int DEPTH = MAX_DELAY + 1;
    localparam int EXT_W = (OUT_W > SUM_W) ? OUT_W : SUM_W;
    localparam logic [DL_W-1:0] MAX_DL   = DL_W'(MAX_DELAY);
    localparam logic [DL_W:0]   DEPTH_V  = (DL_W + 1)'(DEPTH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                   state, state_nx;
    logic [DL_W-1:0]          delay_tab [NUM_CH];
    logic [DL_W-1:0]          shadow    [NUM_CH];
    logic signed [DATA_W-1:0] dline     [NUM_CH][DEPTH];
    logic [DL_W-1:0]          wp, wp_frame;
    logic [CH_W-1:0]          ch;
    logic signed [SUM_W-1:0]  acc;
    logic [DL_W:0]            rd_sum;
    logic [DL_W-1:0]          rd_idx;
    logic signed [DATA_W-1:0] rd_sample;
    logic [OUT_W-1:0]         fit;
    logic                     accept;

    assign busy   = (state != IDLE);
    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = ACC;
            ACC:     if (ch == LAST_CH) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read slot is taken modulo DEPTH, which need not be a power of two.
    always_comb begin
        rd_sum = {1'b0, wp_frame} + DEPTH_V - {1'b0, shadow[ch]};
        if (rd_sum >= DEPTH_V) rd_sum = rd_sum - DEPTH_V;
        rd_idx    = rd_sum[DL_W-1:0];
        rd_sample = dline[ch][rd_idx];
    end

`ifdef BEAMFORM_SAT_EN
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    logic signed [EXT_W-1:0] scaled_ext;
    assign scaled_ext = EXT_W'(acc >>> SHIFT);
    always_comb begin
        fit = scaled_ext[OUT_W-1:0];
        if (OUT_W < SUM_W - SHIFT) begin
            if (scaled_ext > EXT_W'(OUT_MAX))      fit = OUT_MAX;
            else if (scaled_ext < EXT_W'(OUT_MIN)) fit = OUT_MIN;
        end
    end
`else
    assign fit = OUT_W'(EXT_W'(acc >>> SHIFT));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) delay_tab[c] <= '0;
        end else if (cfg_we && ({1'b0, cfg_ch} < NUM_CH_V)) begin
            delay_tab[cfg_ch] <= (cfg_delay > MAX_DL) ? MAX_DL : cfg_delay;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] <= '0;
                for (int d = 0; d < DEPTH; d++) dline[c][d] <= '0;
            end
            wp        <= '0;
            wp_frame  <= '0;
            ch        <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                for (int c = 0; c < NUM_CH; c++) dline[c][wp] <= in_data[c*DATA_W +: DATA_W];
                shadow   <= delay_tab;
                wp_frame <= wp;
                wp       <= (wp == MAX_DL) ? '0 : wp + 1'b1;
                acc      <= '0;
                ch       <= '0;
            end
            if (state == ACC) begin
                acc <= acc + SUM_W'(rd_sample);
                ch  <= (ch == LAST_CH) ? '0 : ch + 1'b1;
            end
            if (state == OUT) begin
                out_valid <= 1'b1;
                out_data  <= fit;
            end
            // A drop wins over a simultaneous clear.
            if (in_valid && busy) overrun <= 1'b1;
            else if (ovr_clr)     overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_beamform_core.sv
// tb/tb_beamform_core.sv - directed table-driven bench for beamform_core
module tb_beamform_core;
    localparam int NUM_CH = 16;
    localparam int DATA_W = 19;
    localparam int W      = NUM_CH * DATA_W;
    localparam int LAT    = NUM_CH + 1;

`ifdef BEAMFORM_SAT_EN
    localparam longint E16_MAX = 32767;
    localparam longint E16_MIN = -32768;
    localparam longint E16_CH0 = 32767;
`else
    localparam longint E16_MAX = -16;
    localparam longint E16_MIN = 0;
    localparam longint E16_CH0 = -1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_ch = '0;
    logic [4:0]    cfg_delay = '0;
    logic          ovr_clr = 1'b0;

    logic          out_valid, busy, overrun;
    logic [31:0]   out_data;
    logic          out_valid_16, busy_16, overrun_16;
    logic [15:0]   out_data_16;
    logic          out_valid_c, busy_c, overrun_c;
    logic [31:0]   out_data_c;

    int n_checks = 0;
    int n_errors = 0;

    beamform_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .ovr_clr(ovr_clr),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .overrun(overrun)
    );

    beamform_core #(.OUT_W(16)) dut_16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .ovr_clr(ovr_clr),
        .out_valid(out_valid_16), .out_data(out_data_16), .busy(busy_16), .overrun(overrun_16)
    );

    beamform_core #(.MAX_DELAY(20)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .ovr_clr(ovr_clr),
        .out_valid(out_valid_c), .out_data(out_data_c), .busy(busy_c), .overrun(overrun_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] din;
        longint       exp32;
        longint       exp16;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] put(input logic [W-1:0] base, input int c, input int v);
        logic [W-1:0] r;
        r = base;
        r[c*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic set_delay(input int c, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 4'(c); cfg_delay = 5'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Strobe one frame, then wait (bounded) for the output pulse.
    task automatic run_frame(input logic [W-1:0] d, output longint o32, output longint o16,
                             output longint oc);
        int lat;
        @(negedge clk);
        in_data = d; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, LAT);
        check("valid_16", out_valid_16, 1);
        check("valid_c", out_valid_c, 1);
        o32 = $signed(out_data);
        o16 = $signed(out_data_16);
        oc  = $signed(out_data_c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        longint o32, o16, oc, dn;
        int pulses, lat;
        logic [W-1:0] d;

        d = '0;
        for (int c = 0; c < NUM_CH; c++) d = put(d, c, c + 1);
        vecs[0] = '{"ramp", d, 136, 136};
        vecs[1] = '{"ones", fill(1), 16, 16};
        vecs[2] = '{"neg_ones", fill(-1), -16, -16};
        vecs[3] = '{"all_max", fill(262143), 4194288, E16_MAX};
        vecs[4] = '{"all_min", fill(-262144), -4194304, E16_MIN};
        d = '0;
        for (int c = 0; c < NUM_CH; c++) d = put(d, c, (c % 2 == 0) ? 5 : -3);
        vecs[5] = '{"alternate", d, 16, 16};
        vecs[6] = '{"ch0_max", put('0, 0, 262143), 262143, E16_CH0};

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_out_data_16", out_data_16, 0);
        @(negedge clk); rst = 1'b0;

        // Reset mid-accumulation: nothing emitted, delay table cleared.
        set_delay(0, 5);
        @(negedge clk);
        in_data = fill(7); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midacc_busy", busy, 0);
        check("midacc_out_valid", out_valid, 0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("midacc_no_pulse", pulses, 0);
        run_frame(fill(1), o32, o16, oc);
        check("post_reset_sum", o32, 16);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].din, o32, o16, oc);
            check({vecs[i].name, "_out32"}, o32, vecs[i].exp32);
            check({vecs[i].name, "_out16"}, o16, vecs[i].exp16);
        end

        // Channel 3 delayed by two frames.
        do_reset();
        set_delay(3, 2);
        run_frame(put('0, 3, 100), o32, o16, oc);
        check("delay2_f1", o32, 0);
        run_frame(put('0, 3, 200), o32, o16, oc);
        check("delay2_f2", o32, 0);
        run_frame(put('0, 3, 300), o32, o16, oc);
        check("delay2_f3", o32, 100);

        // Maximum delay across pointer wrap; dut_c clamps the same write to 20.
        do_reset();
        set_delay(0, 31);
        for (int n = 1; n <= 70; n++) begin
            run_frame(put('0, 0, (n == 1) ? 1000 : n * 3), o32, o16, oc);
            dn = (n - 31 == 1) ? 1000 : (n - 31) * 3;
            check($sformatf("maxdelay_f%0d", n), o32, (n > 31) ? dn : 0);
            dn = (n - 20 == 1) ? 1000 : (n - 20) * 3;
            check($sformatf("clamp20_f%0d", n), oc, (n > 20) ? dn : 0);
        end

        // Overrun: dropped frames neither write nor advance the pointer.
        do_reset();
        set_delay(1, 1);
        check("ovr_before", overrun, 0);
        @(negedge clk);
        in_data = fill(2); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        in_data = fill(9); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        check("ovr_set", overrun, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; ovr_clr = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; ovr_clr = 1'b0;
        check("ovr_set_wins", overrun, 1);
        lat = -1;
        for (int i = 9; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("ovr_latency", lat, LAT);
        check("ovr_out_unchanged", $signed(out_data), 30);
        repeat (3) @(posedge clk);
        #1 check("out_data_held", $signed(out_data), 30);
        @(negedge clk); ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        run_frame(fill(0), o32, o16, oc);
        check("ovr_wp_not_advanced", o32, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
